// File: rtl/execute_ldst_responder_pkg.sv
// Shared definitions for the load/store responder slice.
// Order codes follow the core-wide byte/half/word encoding.
package execute_ldst_responder_pkg;

    localparam logic [1:0] ORDER_BYTE = 2'd0;
    localparam logic [1:0] ORDER_HALF = 2'd1;
    localparam logic [1:0] ORDER_WORD = 2'd2;
    localparam logic [1:0] ORDER_BAD  = 2'd3;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  order;
        logic [3:0]  mask;
        logic [1:0]  shift;
        logic [4:0]  dest;
    } ldst_req_t;

endpackage

// File: rtl/execute_load_data_align.sv
// Load lane extraction: picks the byte/half/word selected by order and
// shift out of the raw memory word and zero-extends it.
module execute_load_data_align
    import execute_ldst_responder_pkg::*;
(
    input  logic [1:0]  order_i,
    input  logic [1:0]  shift_i,
    input  logic [31:0] data_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select, then zero-extend according to the access order.
    always_comb begin
        byte_sel = data_i[7:0];
        unique case (shift_i)
            2'd1:    byte_sel = data_i[15:8];
            2'd2:    byte_sel = data_i[23:16];
            2'd3:    byte_sel = data_i[31:24];
            default: byte_sel = data_i[7:0];
        endcase
        half_sel = shift_i[1] ? data_i[31:16] : data_i[15:0];
        result_o = '0;
        unique case (order_i)
            ORDER_BYTE: result_o = {24'h0, byte_sel};
            ORDER_HALF: result_o = {16'h0, half_sel};
            ORDER_WORD: result_o = data_i;
            default:    result_o = '0;
        endcase
    end

endmodule

// File: rtl/execute_ldst_responder.sv
// Single-outstanding load/store sequencer between execute, the data
// memory port and writeback.
module execute_ldst_responder
    import execute_ldst_responder_pkg::*;
(
    input  logic        iCLOCK,
    input  logic        iRESET_SYNC,
    input  logic        iLDST_REQ,
    output logic        oLDST_BUSY,
    input  logic        iLDST_RW,
    input  logic [31:0] iLDST_ADDR,
    input  logic [31:0] iLDST_DATA,
    input  logic [1:0]  iLDST_ORDER,
    input  logic [3:0]  iLDST_MASK,
    input  logic [1:0]  iLOAD_SHIFT,
    input  logic [4:0]  iLDST_DEST,
    output logic        oDATAIO_REQ,
    input  logic        iDATAIO_BUSY,
    output logic        oDATAIO_RW,
    output logic [31:0] oDATAIO_ADDR,
    output logic [31:0] oDATAIO_DATA,
    output logic [1:0]  oDATAIO_ORDER,
    output logic [3:0]  oDATAIO_MASK,
    input  logic        iDATAIO_VALID,
    input  logic [31:0] iDATAIO_DATA,
    output logic        oOUT_VALID,
    input  logic        iWB_BUSY,
    output logic        oOUT_RW,
    output logic [31:0] oOUT_DATA,
    output logic [4:0]  oOUT_DEST,
    output logic        oOUT_ALIGN_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    ldst_req_t   req_q, req_d;
    logic [31:0] out_data_q, out_data_d;
    logic        err_q, err_d;
    logic [31:0] aligned;

    execute_load_data_align u_align (
        .order_i  (req_q.order),
        .shift_i  (req_q.shift),
        .data_i   (iDATAIO_DATA),
        .result_o (aligned)
    );

    // Next state: capture on accept, bypass memory for bad requests,
    // collect the response only while waiting for it.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        out_data_d = out_data_q;
        err_d      = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (iLDST_REQ) begin
                    req_d.rw    = iLDST_RW;
                    req_d.addr  = iLDST_ADDR;
                    req_d.data  = iLDST_DATA;
                    req_d.order = iLDST_ORDER;
                    req_d.mask  = iLDST_MASK;
                    req_d.shift = iLOAD_SHIFT;
                    req_d.dest  = iLDST_DEST;
                    out_data_d  = '0;
                    if (iLDST_MASK == 4'h0 || iLDST_ORDER == ORDER_BAD) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (!iDATAIO_BUSY) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (iDATAIO_VALID) begin
                    out_data_d = req_q.rw ? 32'h0 : aligned;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!iWB_BUSY) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and captured fields; reset wins over every other event.
    always_ff @(posedge iCLOCK) begin
        if (iRESET_SYNC) begin
            state_q    <= ST_IDLE;
            req_q      <= '0;
            out_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            out_data_q <= out_data_d;
            err_q      <= err_d;
        end
    end

    assign oLDST_BUSY     = (state_q != ST_IDLE);
    assign oDATAIO_REQ    = (state_q == ST_REQ);
    assign oDATAIO_RW     = req_q.rw;
    assign oDATAIO_ADDR   = req_q.addr;
    assign oDATAIO_DATA   = req_q.data;
    assign oDATAIO_ORDER  = req_q.order;
    assign oDATAIO_MASK   = req_q.mask;
    assign oOUT_VALID     = (state_q == ST_DONE);
    assign oOUT_RW        = req_q.rw;
    assign oOUT_DATA      = out_data_q;
    assign oOUT_DEST      = req_q.dest;
    assign oOUT_ALIGN_ERR = err_q;

endmodule

// File: tb/tb_execute_ldst_responder.sv
// Scoreboard bench for execute_ldst_responder: directed latency and
// reset cases, then randomized traffic against a behavioural model.
module tb_execute_ldst_responder;

    logic        iCLOCK;
    logic        iRESET_SYNC;
    logic        iLDST_REQ;
    logic        oLDST_BUSY;
    logic        iLDST_RW;
    logic [31:0] iLDST_ADDR;
    logic [31:0] iLDST_DATA;
    logic [1:0]  iLDST_ORDER;
    logic [3:0]  iLDST_MASK;
    logic [1:0]  iLOAD_SHIFT;
    logic [4:0]  iLDST_DEST;
    logic        oDATAIO_REQ;
    logic        iDATAIO_BUSY;
    logic        oDATAIO_RW;
    logic [31:0] oDATAIO_ADDR;
    logic [31:0] oDATAIO_DATA;
    logic [1:0]  oDATAIO_ORDER;
    logic [3:0]  oDATAIO_MASK;
    logic        iDATAIO_VALID;
    logic [31:0] iDATAIO_DATA;
    logic        oOUT_VALID;
    logic        iWB_BUSY;
    logic        oOUT_RW;
    logic [31:0] oOUT_DATA;
    logic [4:0]  oOUT_DEST;
    logic        oOUT_ALIGN_ERR;

    execute_ldst_responder dut (
        .iCLOCK         (iCLOCK),
        .iRESET_SYNC    (iRESET_SYNC),
        .iLDST_REQ      (iLDST_REQ),
        .oLDST_BUSY     (oLDST_BUSY),
        .iLDST_RW       (iLDST_RW),
        .iLDST_ADDR     (iLDST_ADDR),
        .iLDST_DATA     (iLDST_DATA),
        .iLDST_ORDER    (iLDST_ORDER),
        .iLDST_MASK     (iLDST_MASK),
        .iLOAD_SHIFT    (iLOAD_SHIFT),
        .iLDST_DEST     (iLDST_DEST),
        .oDATAIO_REQ    (oDATAIO_REQ),
        .iDATAIO_BUSY   (iDATAIO_BUSY),
        .oDATAIO_RW     (oDATAIO_RW),
        .oDATAIO_ADDR   (oDATAIO_ADDR),
        .oDATAIO_DATA   (oDATAIO_DATA),
        .oDATAIO_ORDER  (oDATAIO_ORDER),
        .oDATAIO_MASK   (oDATAIO_MASK),
        .iDATAIO_VALID  (iDATAIO_VALID),
        .iDATAIO_DATA   (iDATAIO_DATA),
        .oOUT_VALID     (oOUT_VALID),
        .iWB_BUSY       (iWB_BUSY),
        .oOUT_RW        (oOUT_RW),
        .oOUT_DATA      (oOUT_DATA),
        .oOUT_DEST      (oOUT_DEST),
        .oOUT_ALIGN_ERR (oOUT_ALIGN_ERR)
    );

    typedef struct {
        logic        rw;
        logic [31:0] data;
        logic [4:0]  dest;
        logic        err;
    } out_t;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  order;
        logic [3:0]  mask;
    } mreq_t;

    out_t  exp_out[$];
    mreq_t exp_req[$];

    int errors = 0;
    int checks = 0;

    int          busy_left = 0;
    int          resp_dly_cfg = 0;
    logic [31:0] mem_word = 32'h0;
    int          wb_force = 0;
    bit          wb_rand = 0;
    bit          noise_en = 0;
    int          req_cycles = 0;
    int          last_req_cycles = 0;
    bit          hs_seen = 0;

    bit          pend = 0;
    int          dly = 0;
    bit          pv = 0;
    bit          pb = 0;
    logic [31:0] pdata;
    logic        prw;
    logic [4:0]  pdest;
    logic        perr;

    initial begin
        iCLOCK = 1'b0;
        forever #5 iCLOCK = ~iCLOCK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Reference behaviour: what writeback must see for one request.
    function automatic out_t model(input logic rw, input logic [1:0] order,
                                   input logic [3:0] mask,
                                   input logic [1:0] shift,
                                   input logic [4:0] dest,
                                   input logic [31:0] mem);
        out_t r;
        r.rw   = rw;
        r.dest = dest;
        r.err  = (mask == 4'h0) || (order == 2'd3);
        r.data = 32'h0;
        if (!r.err && !rw) begin
            if (order == 2'd0)
                r.data = (mem >> (8 * int'(shift))) & 32'h0000_00FF;
            else if (order == 2'd1)
                r.data = (mem >> (8 * int'(shift))) & 32'h0000_FFFF;
            else
                r.data = mem;
        end
        return r;
    endfunction

    // Memory side: checks every request cycle, applies busy, returns data.
    initial begin
        mreq_t m;
        iDATAIO_BUSY  = 1'b0;
        iDATAIO_VALID = 1'b0;
        iDATAIO_DATA  = 32'h0;
        forever begin
            @(negedge iCLOCK);
            iDATAIO_VALID = 1'b0;
            if (pend) begin
                if (dly == 0) begin
                    iDATAIO_VALID = 1'b1;
                    iDATAIO_DATA  = mem_word;
                    pend = 0;
                end else begin
                    dly--;
                end
            end else if (noise_en && $urandom_range(0, 3) == 0) begin
                iDATAIO_VALID = 1'b1;
                iDATAIO_DATA  = $urandom();
            end
            if (oDATAIO_REQ) begin
                req_cycles++;
                if (exp_req.size() == 0) begin
                    chk1("unexpected_dataio_req", 1'b1, 1'b0);
                end else begin
                    m = exp_req[0];
                    chk1("dataio_rw", oDATAIO_RW, m.rw);
                    chk("dataio_addr", oDATAIO_ADDR, m.addr);
                    chk("dataio_data", oDATAIO_DATA, m.data);
                    chk("dataio_order", 32'(oDATAIO_ORDER), 32'(m.order));
                    chk("dataio_mask", 32'(oDATAIO_MASK), 32'(m.mask));
                end
                if (busy_left > 0) begin
                    iDATAIO_BUSY = 1'b1;
                    busy_left--;
                end else begin
                    iDATAIO_BUSY = 1'b0;
                    pend = 1;
                    dly = resp_dly_cfg;
                    last_req_cycles = req_cycles;
                    req_cycles = 0;
                    hs_seen = 1;
                    if (exp_req.size() > 0) void'(exp_req.pop_front());
                end
            end else begin
                iDATAIO_BUSY = 1'($urandom_range(0, 1));
            end
        end
    end

    // Writeback side: drives backpressure, checks results and stability.
    initial begin
        out_t e;
        iWB_BUSY = 1'b0;
        forever begin
            @(negedge iCLOCK);
            if (oOUT_VALID) begin
                chk1("busy_in_done", oLDST_BUSY, 1'b1);
                if (pv && pb) begin
                    chk("out_stable_data", oOUT_DATA, pdata);
                    chk1("out_stable_rw", oOUT_RW, prw);
                    chk("out_stable_dest", 32'(oOUT_DEST), 32'(pdest));
                    chk1("out_stable_err", oOUT_ALIGN_ERR, perr);
                end
                if (wb_force > 0) begin
                    iWB_BUSY = 1'b1;
                    wb_force--;
                end else begin
                    iWB_BUSY = wb_rand ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if (!iWB_BUSY) begin
                    if (exp_out.size() == 0) begin
                        chk1("unexpected_out_valid", 1'b1, 1'b0);
                    end else begin
                        e = exp_out.pop_front();
                        chk("out_data", oOUT_DATA, e.data);
                        chk1("out_rw", oOUT_RW, e.rw);
                        chk("out_dest", 32'(oOUT_DEST), 32'(e.dest));
                        chk1("out_align_err", oOUT_ALIGN_ERR, e.err);
                    end
                end
            end else begin
                iWB_BUSY = wb_rand ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            pv    = oOUT_VALID;
            pb    = iWB_BUSY;
            pdata = oOUT_DATA;
            prw   = oOUT_RW;
            pdest = oOUT_DEST;
            perr  = oOUT_ALIGN_ERR;
        end
    end

    // Wait for IDLE, program the memory model, drive one request.
    // Returns one time unit after the accepting edge.
    task automatic issue(input logic rw, input logic [31:0] addr,
                         input logic [31:0] data, input logic [1:0] order,
                         input logic [3:0] mask, input logic [1:0] shift,
                         input logic [4:0] dest, input logic [31:0] mem,
                         input int busy, input int rdly);
        int n = 0;
        out_t  o;
        mreq_t m;
        @(negedge iCLOCK);
        while (oLDST_BUSY && n < 200) begin
            @(negedge iCLOCK);
            n++;
        end
        if (oLDST_BUSY) begin
            chk1("accept_timeout", 1'b1, 1'b0);
            return;
        end
        mem_word     = mem;
        busy_left    = busy;
        resp_dly_cfg = rdly;
        o = model(rw, order, mask, shift, dest, mem);
        exp_out.push_back(o);
        if (!o.err) begin
            m.rw = rw; m.addr = addr; m.data = data;
            m.order = order; m.mask = mask;
            exp_req.push_back(m);
        end
        iLDST_RW    = rw;
        iLDST_ADDR  = addr;
        iLDST_DATA  = data;
        iLDST_ORDER = order;
        iLDST_MASK  = mask;
        iLOAD_SHIFT = shift;
        iLDST_DEST  = dest;
        iLDST_REQ   = 1'b1;
        @(posedge iCLOCK);
        #1;
        iLDST_REQ   = 1'b0;
        iLDST_ADDR  = $urandom();
        iLDST_DATA  = $urandom();
    endtask

    task automatic wait_out();
        int n = 0;
        @(negedge iCLOCK);
        while (!oOUT_VALID && n < 100) begin
            @(negedge iCLOCK);
            n++;
        end
        if (!oOUT_VALID) chk1("out_valid_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge iCLOCK);
        while ((oLDST_BUSY || exp_out.size() != 0) && n < 200) begin
            @(negedge iCLOCK);
            n++;
        end
    endtask

    initial begin
        logic        rw;
        logic [1:0]  order;
        logic [1:0]  shift;
        logic [3:0]  mask;
        logic [31:0] addr;
        int          r;
        int          n;
        bit          seen;

        iRESET_SYNC = 1'b1;
        iLDST_REQ   = 1'b0;
        iLDST_RW    = 1'b0;
        iLDST_ADDR  = 32'h0;
        iLDST_DATA  = 32'h0;
        iLDST_ORDER = 2'd0;
        iLDST_MASK  = 4'h0;
        iLOAD_SHIFT = 2'd0;
        iLDST_DEST  = 5'd0;
        repeat (3) @(negedge iCLOCK);
        chk1("reset_busy", oLDST_BUSY, 1'b0);
        chk1("reset_dataio_req", oDATAIO_REQ, 1'b0);
        chk1("reset_out_valid", oOUT_VALID, 1'b0);
        chk("reset_out_data", oOUT_DATA, 32'h0);
        chk("reset_dataio_addr", oDATAIO_ADDR, 32'h0);
        chk1("reset_align_err", oOUT_ALIGN_ERR, 1'b0);
        iRESET_SYNC = 1'b0;

        // Load byte at lane 3, zero wait states.
        issue(1'b0, 32'h0000_1003, 32'h0, 2'd0, 4'b1000, 2'd3, 5'd7,
              32'hA1B2_C3D4, 0, 0);
        @(negedge iCLOCK);
        chk1("lb_t1_dataio_req", oDATAIO_REQ, 1'b1);
        chk1("lb_t1_out_valid", oOUT_VALID, 1'b0);
        @(negedge iCLOCK);
        chk1("lb_t2_dataio_req", oDATAIO_REQ, 1'b0);
        chk1("lb_t2_out_valid", oOUT_VALID, 1'b0);
        @(negedge iCLOCK);
        chk1("lb_t3_out_valid", oOUT_VALID, 1'b1);
        chk("lb_t3_out_data", oOUT_DATA, 32'h0000_00A1);
        @(negedge iCLOCK);
        chk1("lb_t4_busy", oLDST_BUSY, 1'b0);

        // Load half at lane 2 with three busy cycles on the memory port.
        issue(1'b0, 32'h0000_0402, 32'h0, 2'd1, 4'b1100, 2'd2, 5'd3,
              32'h1234_5678, 3, 1);
        wait_out();
        chk("lh_req_cycles", 32'(last_req_cycles), 32'd4);
        chk("lh_out_data", oOUT_DATA, 32'h0000_1234);

        // Store word.
        issue(1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 2'd2, 4'b1111, 2'd0,
              5'd9, 32'h5555_AAAA, 0, 2);
        wait_out();
        chk1("sw_out_rw", oOUT_RW, 1'b1);
        chk("sw_out_data", oOUT_DATA, 32'h0);

        // Empty mask: no memory access, result next cycle with error.
        issue(1'b0, 32'h0000_0301, 32'h0, 2'd1, 4'b0000, 2'd0, 5'd12,
              32'hFFFF_FFFF, 0, 0);
        @(negedge iCLOCK);
        chk1("mis_t1_out_valid", oOUT_VALID, 1'b1);
        chk1("mis_t1_align_err", oOUT_ALIGN_ERR, 1'b1);
        chk1("mis_t1_dataio_req", oDATAIO_REQ, 1'b0);
        chk("mis_t1_out_data", oOUT_DATA, 32'h0);

        // Writeback backpressure held for five cycles.
        wb_force = 5;
        issue(1'b0, 32'h0000_0500, 32'h0, 2'd2, 4'b1111, 2'd1, 5'd20,
              32'h0BAD_F00D, 0, 0);
        wait_out();
        n = 0;
        while (oOUT_VALID && n < 20) begin
            chk1("wb_hold_busy", oLDST_BUSY, 1'b1);
            @(negedge iCLOCK);
            n++;
        end
        chk("wb_hold_cycles", 32'(n), 32'd6);
        issue(1'b0, 32'h0000_0600, 32'h0, 2'd0, 4'b0001, 2'd0, 5'd21,
              32'h0000_0077, 0, 0);
        wait_idle();

        // Reset while waiting on memory; the late response is ignored.
        hs_seen = 0;
        issue(1'b0, 32'h0000_0700, 32'h0, 2'd2, 4'b1111, 2'd0, 5'd5,
              32'h7777_7777, 0, 4);
        n = 0;
        while (!hs_seen && n < 20) begin
            @(negedge iCLOCK);
            n++;
        end
        @(negedge iCLOCK);
        chk1("rst_wait_busy", oLDST_BUSY, 1'b1);
        chk1("rst_wait_dataio_req", oDATAIO_REQ, 1'b0);
        iRESET_SYNC = 1'b1;
        exp_out.delete();
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        chk1("rst_mid_busy", oLDST_BUSY, 1'b0);
        seen = 0;
        repeat (8) begin
            @(negedge iCLOCK);
            if (oOUT_VALID) seen = 1;
        end
        chk1("rst_no_out_valid", seen, 1'b0);
        issue(1'b0, 32'h0000_0801, 32'h0, 2'd0, 4'b0010, 2'd1, 5'd6,
              32'h0102_0304, 0, 1);
        wait_out();
        chk("rst_after_load", oOUT_DATA, 32'h0000_0003);
        wait_idle();

        // Reset and a request in the same cycle: reset wins.
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b1;
        iLDST_REQ   = 1'b1;
        iLDST_MASK  = 4'hF;
        iLDST_ORDER = 2'd2;
        @(negedge iCLOCK);
        iRESET_SYNC = 1'b0;
        iLDST_REQ   = 1'b0;
        chk1("rst_prio_busy", oLDST_BUSY, 1'b0);
        repeat (4) @(negedge iCLOCK);

        // Randomized traffic with backpressure and response noise.
        wb_rand  = 1;
        noise_en = 1;
        for (int i = 0; i < 60; i++) begin
            rw = 1'($urandom_range(0, 1));
            r  = $urandom_range(0, 9);
            order = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            shift = 2'($urandom_range(0, 3));
            if (order == 2'd1) shift = {shift[1], 1'b0};
            case (order)
                2'd0:    mask = 4'b0001 << shift;
                2'd1:    mask = shift[1] ? 4'b1100 : 4'b0011;
                default: mask = 4'b1111;
            endcase
            if ($urandom_range(0, 7) == 0) mask = 4'h0;
            addr = $urandom();
            addr[1:0] = shift;
            issue(rw, addr, $urandom(), order, mask, shift,
                  5'($urandom_range(0, 31)), $urandom(),
                  $urandom_range(0, 2), $urandom_range(0, 3));
        end
        wait_idle();
        wb_rand  = 0;
        noise_en = 0;
        repeat (3) @(negedge iCLOCK);
        chk("scoreboard_drained", 32'(exp_out.size()), 32'd0);
        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/execute_ldst_responder.md
EXECUTE_LDST_RESPONDER -- requirements
Module: execute_ldst_responder

Interface
REQ-001 SHALL expose iCLOCK in 1: sole clock, all state updates on rising edge.
REQ-002 SHALL expose iRESET_SYNC in 1: synchronous, active-high reset.
REQ-003 SHALL expose iLDST_REQ in 1: upstream request valid; oLDST_BUSY out 1: not accepting.
REQ-004 SHALL expose iLDST_RW in 1 (0 load, 1 store), iLDST_ADDR in 32, iLDST_DATA in 32 (store data, pre-lane-aligned), iLDST_ORDER in 2 (0 byte, 1 half, 2 word), iLDST_MASK in 4 (byte enables), iLOAD_SHIFT in 2 (byte lane), iLDST_DEST in 5 (writeback register tag).
REQ-005 SHALL expose oDATAIO_REQ out 1, iDATAIO_BUSY in 1, oDATAIO_RW out 1, oDATAIO_ADDR out 32, oDATAIO_DATA out 32, oDATAIO_ORDER out 2, oDATAIO_MASK out 4: memory request port.
REQ-006 SHALL expose iDATAIO_VALID in 1, iDATAIO_DATA in 32: memory response (load data or store acknowledge).
REQ-007 SHALL expose oOUT_VALID out 1, iWB_BUSY in 1, oOUT_RW out 1, oOUT_DATA out 32, oOUT_DEST out 5, oOUT_ALIGN_ERR out 1: writeback result port.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, WAIT, DONE; one transaction outstanding maximum.
REQ-009 SHALL drive oLDST_BUSY=0 only in IDLE; request accepted when IDLE and iLDST_REQ=1, all iLDST_* fields registered that edge.
REQ-010 SHALL, on accept with iLDST_MASK!=0 and iLDST_ORDER!=3, enter REQ.
REQ-011 SHALL, on accept with iLDST_MASK==0 or iLDST_ORDER==3, skip memory, enter DONE with oOUT_ALIGN_ERR=1, oOUT_DATA=0.
REQ-012 SHALL in REQ hold oDATAIO_REQ=1 with registered fields stable; when iDATAIO_BUSY=0 that cycle, handshake completes and state goes to WAIT; else remain REQ.
REQ-013 SHALL drive oDATAIO_REQ=0 in all states other than REQ.
REQ-014 SHALL sample iDATAIO_VALID only in WAIT; VALID in IDLE, REQ or DONE SHALL be ignored.
REQ-015 SHALL on VALID in WAIT register aligned result and enter DONE.
REQ-016 SHALL align loads: order 0 -> zero-extended byte iDATAIO_DATA[8*shift+7:8*shift]; order 1 -> zero-extended halfword at shift 0 or 2; order 2 -> full word, shift ignored.
REQ-017 SHALL for stores set oOUT_DATA=0 and oOUT_RW=1 upon acknowledge VALID.
REQ-018 SHALL in DONE hold oOUT_VALID=1 with stable oOUT_*; leave to IDLE on the edge where iWB_BUSY=0.
REQ-019 SHALL give minimum latency accept(t) -> oDATAIO_REQ(t+1) -> VALID sampled earliest t+2 -> oOUT_VALID(t+3) -> IDLE t+4.
REQ-020 SHALL not accept a new request in the cycle DONE is left (no bypass); next accept earliest the following cycle.

Reset
REQ-021 SHALL on iRESET_SYNC=1 at an edge force IDLE and clear all registered outputs/fields to 0 (oLDST_BUSY=0 combinationally from IDLE).
REQ-022 SHALL abandon any outstanding transaction on reset mid-operation; a subsequent iDATAIO_VALID SHALL be ignored and produce no oOUT_VALID.
REQ-023 SHALL give reset priority over all concurrent events, including iLDST_REQ and iDATAIO_VALID.

Structure
REQ-024 SHALL take order codes (byte/half/word) from the shared core.h definitions; FSM state encoding SHALL stay local.
REQ-025 SHALL place lane extraction in one combinational sub-module execute_load_data_align (inputs order, shift, data; output 32-bit result).
REQ-026 SHALL contain no memory arrays; total flops below 120.

Verification
REQ-027 Load byte: addr 0x1003, order 0, mask 1000, shift 3, memory data 0xA1B2C3D4 -> oOUT_DATA 0x000000A1, oOUT_VALID at t+3.
REQ-028 Load half, shift 2, data 0x12345678, iDATAIO_BUSY high 3 cycles -> oDATAIO_REQ held 4 cycles stable, oOUT_DATA 0x00001234.
REQ-029 Store word addr 0x2000 data 0xDEADBEEF -> oDATAIO_RW=1, mask 1111; ack VALID -> oOUT_RW=1, oOUT_DATA 0.
REQ-030 Misaligned half (mask 0000) -> no oDATAIO_REQ, oOUT_VALID at t+1 with oOUT_ALIGN_ERR=1.
REQ-031 iWB_BUSY high 5 cycles in DONE -> oOUT_VALID held, oLDST_BUSY=1 throughout; new request accepted only after release.
REQ-032 Reset asserted in WAIT, then VALID pulse -> state IDLE, no oOUT_VALID, next load completes normally.
